// File: rtl/ctrl_pipeline_pkg.sv
// ctrl_pipeline_pkg
//   Shared definitions for the control pipeline: bundle widths, bit
//   positions inside the EX/MEM/WB control bundles, forwarding-select
//   encodings, the opcode constants shared with the main decoder, and the
//   forwarding priority function used by the hazard/forward unit.
package ctrl_pipeline_pkg;

    // Widths
    localparam int REG_W = 5;   // register index width
    localparam int EX_W  = 4;   // {regDest, aluOp[1:0], aluSrc}
    localparam int MEM_W = 3;   // {branch, memRead, memWrite}
    localparam int WB_W  = 2;   // {regWrite, memToReg}

    // EX bundle bit positions
    localparam int EX_REGDST   = 3;
    localparam int EX_ALUOP_HI = 2;
    localparam int EX_ALUOP_LO = 1;
    localparam int EX_ALUSRC   = 0;

    // MEM bundle bit positions
    localparam int MEM_BRANCH = 2;
    localparam int MEM_READ   = 1;
    localparam int MEM_WRITE  = 0;

    // WB bundle bit positions
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

    // ALU operand source selects
    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b10,
        FWD_MEMWB = 2'b01
    } fwd_sel_e;

    // Opcodes understood by the main decoder that feeds this block
    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_BEQ   = 6'h04,
        OP_ADDI  = 6'h08,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2b
    } opcode_e;

    // Forwarding priority: the EX/MEM result is newer than the MEM/WB
    // result, so it wins when both stages write the same source register.
    // Register 0 is hard-wired to zero and is never forwarded.
    function automatic fwd_sel_e fwd_select(
        input logic [REG_W-1:0] src,
        input logic             exmem_reg_write,
        input logic [REG_W-1:0] exmem_dst,
        input logic             memwb_reg_write,
        input logic [REG_W-1:0] memwb_dst
    );
        fwd_sel_e sel;
        sel = FWD_RF;
        if (exmem_reg_write && (exmem_dst != '0) && (exmem_dst == src)) begin
            sel = FWD_EXMEM;
        end else if (memwb_reg_write && (memwb_dst != '0) && (memwb_dst == src)) begin
            sel = FWD_MEMWB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/ctrl_pipeline_if.sv
// ctrl_pipeline_if
//   Groups the decoder-side inputs and the per-stage datapath controls of
//   the control pipeline.
//   master : decoder / datapath side (drives id_*, receives stage controls)
//   slave  : ctrl_pipeline side (receives id_*, drives stage controls)
interface ctrl_pipeline_if;
    import ctrl_pipeline_pkg::*;

    // ID stage inputs
    logic [EX_W-1:0]  id_ex;
    logic [MEM_W-1:0] id_mem;
    logic [WB_W-1:0]  id_wb;
    logic             id_flush;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic [REG_W-1:0] id_rd;

    // Per-stage controls
    logic             ex_reg_dst;
    logic [1:0]       ex_alu_op;
    logic             ex_alu_src;
    logic             mem_branch;
    logic             mem_read;
    logic             mem_write;
    logic             wb_reg_write;
    logic             wb_mem_to_reg;
    logic [REG_W-1:0] wb_rd;

    // Hazard / forwarding
    logic [1:0]       forward_a;
    logic [1:0]       forward_b;
    logic             stall;
    logic             pc_write;
    logic             ifid_write;

    modport master (
        output id_ex, id_mem, id_wb, id_flush, id_rs, id_rt, id_rd,
        input  ex_reg_dst, ex_alu_op, ex_alu_src,
        input  mem_branch, mem_read, mem_write,
        input  wb_reg_write, wb_mem_to_reg, wb_rd,
        input  forward_a, forward_b, stall, pc_write, ifid_write
    );

    modport slave (
        input  id_ex, id_mem, id_wb, id_flush, id_rs, id_rt, id_rd,
        output ex_reg_dst, ex_alu_op, ex_alu_src,
        output mem_branch, mem_read, mem_write,
        output wb_reg_write, wb_mem_to_reg, wb_rd,
        output forward_a, forward_b, stall, pc_write, ifid_write
    );

endinterface

// File: rtl/ctrl_pipeline_hazard_forward_unit.sv
// hazard_forward_unit
//   Purely combinational load-use hazard detector and EX forwarding unit.
//   Ports:
//     idex_mem_read, idex_rs, idex_rt : instruction currently in EX
//     id_rs, id_rt                    : source fields of the instruction in ID
//     exmem_reg_write, exmem_dst      : writer currently in MEM
//     memwb_reg_write, memwb_dst      : writer currently in WB
//     stall                           : load-use stall request
//     forward_a, forward_b            : ALU operand A/B source selects
module hazard_forward_unit
    import ctrl_pipeline_pkg::*;
(
    input  logic             idex_mem_read,
    input  logic [REG_W-1:0] idex_rs,
    input  logic [REG_W-1:0] idex_rt,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             exmem_reg_write,
    input  logic [REG_W-1:0] exmem_dst,
    input  logic             memwb_reg_write,
    input  logic [REG_W-1:0] memwb_dst,
    output logic             stall,
    output logic [1:0]       forward_a,
    output logic [1:0]       forward_b
);

    // A load in EX whose target is read by the instruction in ID cannot be
    // forwarded in time; hold ID for one cycle. r0 never creates a hazard.
    assign stall = idex_mem_read && (idex_rt != '0) &&
                   ((idex_rt == id_rs) || (idex_rt == id_rt));

    // Operand 0 = A (rs), operand 1 = B (rt)
    logic [REG_W-1:0] src [2];
    logic [1:0]       sel [2];

    assign src[0] = idex_rs;
    assign src[1] = idex_rt;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            assign sel[gi] = fwd_select(src[gi], exmem_reg_write, exmem_dst,
                                        memwb_reg_write, memwb_dst);
        end
    endgenerate

    assign forward_a = sel[0];
    assign forward_b = sel[1];

endmodule

// File: rtl/ctrl_pipeline.sv
// ctrl_pipeline
//   Consumer end of the main decoder's control bundles. Carries the EX, MEM
//   and WB bundles plus register indices through the ID/EX, EX/MEM and
//   MEM/WB registers, unpacks them into named per-stage controls, and hosts
//   the load-use hazard and forwarding logic.
//   Ports:
//     clock : rising-edge clock
//     reset : synchronous, active-low; clears every pipeline register
//     bus   : ctrl_pipeline_if.slave (ID inputs, stage controls, hazard outs)
module ctrl_pipeline
    import ctrl_pipeline_pkg::*;
(
    input  logic           clock,
    input  logic           reset,
    ctrl_pipeline_if.slave bus
);

    // ID/EX
    logic [EX_W-1:0]  idex_ex_reg;
    logic [MEM_W-1:0] idex_mem_reg;
    logic [WB_W-1:0]  idex_wb_reg;
    logic [REG_W-1:0] idex_rs_reg;
    logic [REG_W-1:0] idex_rt_reg;
    logic [REG_W-1:0] idex_rd_reg;

    // EX/MEM
    logic [MEM_W-1:0] exmem_mem_reg;
    logic [WB_W-1:0]  exmem_wb_reg;
    logic [REG_W-1:0] exmem_dst_reg;

    // MEM/WB
    logic [WB_W-1:0]  memwb_wb_reg;
    logic [REG_W-1:0] memwb_dst_reg;

    logic             stall;
    logic             bubble;
    logic [REG_W-1:0] ex_dst_next;
    logic [1:0]       forward_a;
    logic [1:0]       forward_b;

    // A squashed or stalled ID instruction enters EX as an all-zero bundle.
    // Stall together with flush still yields just one bubble.
    assign bubble = stall || bus.id_flush;

    assign ex_dst_next = idex_ex_reg[EX_REGDST] ? idex_rd_reg : idex_rt_reg;

    always_ff @(posedge clock) begin
        if (!reset) begin
            idex_ex_reg   <= '0;
            idex_mem_reg  <= '0;
            idex_wb_reg   <= '0;
            idex_rs_reg   <= '0;
            idex_rt_reg   <= '0;
            idex_rd_reg   <= '0;
            exmem_mem_reg <= '0;
            exmem_wb_reg  <= '0;
            exmem_dst_reg <= '0;
            memwb_wb_reg  <= '0;
            memwb_dst_reg <= '0;
        end else begin
            idex_ex_reg   <= bubble ? '0 : bus.id_ex;
            idex_mem_reg  <= bubble ? '0 : bus.id_mem;
            idex_wb_reg   <= bubble ? '0 : bus.id_wb;
            // Indices ride along even in a bubble; with zero bundles they
            // cannot write or load, so their value is irrelevant.
            idex_rs_reg   <= bus.id_rs;
            idex_rt_reg   <= bus.id_rt;
            idex_rd_reg   <= bus.id_rd;

            exmem_mem_reg <= idex_mem_reg;
            exmem_wb_reg  <= idex_wb_reg;
            exmem_dst_reg <= ex_dst_next;

            memwb_wb_reg  <= exmem_wb_reg;
            memwb_dst_reg <= exmem_dst_reg;
        end
    end

    hazard_forward_unit u_hazard_forward_unit (
        .idex_mem_read   (idex_mem_reg[MEM_READ]),
        .idex_rs         (idex_rs_reg),
        .idex_rt         (idex_rt_reg),
        .id_rs           (bus.id_rs),
        .id_rt           (bus.id_rt),
        .exmem_reg_write (exmem_wb_reg[WB_REGWRITE]),
        .exmem_dst       (exmem_dst_reg),
        .memwb_reg_write (memwb_wb_reg[WB_REGWRITE]),
        .memwb_dst       (memwb_dst_reg),
        .stall           (stall),
        .forward_a       (forward_a),
        .forward_b       (forward_b)
    );

    // Per-stage control unpacking
    assign bus.ex_reg_dst    = idex_ex_reg[EX_REGDST];
    assign bus.ex_alu_op     = idex_ex_reg[EX_ALUOP_HI:EX_ALUOP_LO];
    assign bus.ex_alu_src    = idex_ex_reg[EX_ALUSRC];
    assign bus.mem_branch    = exmem_mem_reg[MEM_BRANCH];
    assign bus.mem_read      = exmem_mem_reg[MEM_READ];
    assign bus.mem_write     = exmem_mem_reg[MEM_WRITE];
    assign bus.wb_reg_write  = memwb_wb_reg[WB_REGWRITE];
    assign bus.wb_mem_to_reg = memwb_wb_reg[WB_MEMTOREG];
    assign bus.wb_rd         = memwb_dst_reg;

    assign bus.forward_a  = forward_a;
    assign bus.forward_b  = forward_b;
    assign bus.stall      = stall;
    assign bus.pc_write   = !stall;
    assign bus.ifid_write = !stall;

endmodule

// File: doc/ctrl_pipeline.md
Name: ctrl_pipeline

Overview:
Consumer end of the main control decoder's EX/MEM/WB bundles.
- Carries each instruction's control bundle through the ID/EX, EX/MEM and MEM/WB pipeline registers, together with its register indices.
- Unpacks each bundle into named per-stage control signals for the datapath.
- Contains the load-use hazard unit (stall plus bubble insertion) and the EX forwarding unit.
- Sits between the decoder/register-file stage and the ALU, data-memory and write-back muxes.

Parameters:
REG_W, 5, register index width
EX_W, 4, EX bundle width {regDest, aluOp[1:0], aluSrc}
MEM_W, 3, MEM bundle width {branch, memRead, memWrite}
WB_W, 2, WB bundle width {regWrite, memToReg}

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-low; clears all pipeline state on the rising clock edge while 0
id_ex  in  EX_W  EX bundle from decoder
id_mem  in  MEM_W  MEM bundle from decoder
id_wb  in  WB_W  WB bundle from decoder
id_flush  in  1  1 = squash instruction in ID (bubble into ID/EX)
id_rs  in  REG_W  rs field of the ID instruction
id_rt  in  REG_W  rt field of the ID instruction
id_rd  in  REG_W  rd field of the ID instruction
ex_reg_dst  out  1  EX-stage regDest
ex_alu_op  out  2  EX-stage aluOp
ex_alu_src  out  1  EX-stage aluSrc
mem_branch  out  1  MEM-stage branch
mem_read  out  1  MEM-stage memRead
mem_write  out  1  MEM-stage memWrite
wb_reg_write  out  1  WB-stage regWrite
wb_mem_to_reg  out  1  WB-stage memToReg
wb_rd  out  REG_W  WB destination register
forward_a  out  2  ALU operand A select: 00 register file, 10 EX/MEM, 01 MEM/WB
forward_b  out  2  ALU operand B select, same encoding
stall  out  1  load-use stall indication
pc_write  out  1  PC update enable (= ~stall)
ifid_write  out  1  IF/ID register enable (= ~stall)

Behaviour:
- Reset (reset==0 at a rising edge):
  - All ID/EX, EX/MEM and MEM/WB registers clear to 0, so every stage output is 0.
  - Consequences: wb_rd=0, forward_a/forward_b=00, stall=0, pc_write=1, ifid_write=1.
  - Reset in the middle of a program discards every in-flight instruction; nothing retires after it.
- ID/EX register, at each edge with reset==1:
  - Captures {id_ex, id_mem, id_wb, id_rs, id_rt, id_rd}.
  - If stall==1 or id_flush==1, the three bundles capture 0 (bubble). The index fields are still captured but are don't-care.
- EX/MEM register:
  - Captures the ID/EX MEM and WB bundles unconditionally.
  - Captures ex_dst = ex_reg_dst ? idex_rd : idex_rt.
  - The EX bundle is not carried further.
- MEM/WB register: captures the WB bundle and the destination from EX/MEM unconditionally.
- Latency: a bundle presented in ID appears on the EX outputs 1 cycle later, on the MEM outputs 2 cycles later and on the WB outputs 3 cycles later.
- Hazard detection is combinational:
  - stall = idex_mem_read & (idex_rt != 0) & ((idex_rt == id_rs) | (idex_rt == id_rt)).
  - A stall lasts exactly 1 cycle, because the bubble clears idex_mem_read on the next cycle.
  - If stall and id_flush are high together, the result is a single bubble. pc_write and ifid_write are still held low.
- Forwarding is combinational. Evaluate forward_a with idex_rs and forward_b with idex_rt:
  - Select 10 if exmem_reg_write and exmem_dst != 0 and exmem_dst == src.
  - Otherwise select 01 if memwb_reg_write and memwb_dst != 0 and memwb_dst == src.
  - Otherwise select 00.
  - When both stages match the same source, EX/MEM has priority (it is the newer value).
  - Register 0 is never forwarded and never causes a stall.
- No state machine beyond the three register stages. All comparisons are unsigned and REG_W bits wide.

Decomposition:
- Shared package holds:
  - bundle widths and bit positions: EX_REGDST=3, EX_ALUOP_HI=2, EX_ALUOP_LO=1, EX_ALUSRC=0, MEM_BRANCH=2, MEM_READ=1, MEM_WRITE=0, WB_REGWRITE=1, WB_MEMTOREG=0;
  - forward encodings FWD_RF=2'b00, FWD_EXMEM=2'b10, FWD_MEMWB=2'b01;
  - the opcode constants shared with the decoder.
- One sub-module is natural: hazard_forward_unit, purely combinational, producing stall, forward_a and forward_b. The pipeline registers stay in ctrl_pipeline.

Test Plan:
- Reset held low for 2 cycles with random bundles on the inputs -> all outputs 0, pc_write=1, ifid_write=1; after release, first bundle visible on the EX outputs 1 cycle later.
- R-type (id_ex=4'b1100, id_wb=2'b10, rd=3, rt=2) followed by 3 idle cycles -> ex_alu_op=10 at +1, wb_reg_write=1 and wb_rd=3 at +3.
- lw $t(rt=8) then add using rs=8 -> stall=1 for exactly 1 cycle, pc_write=0; bubble in EX (all EX outputs 0); forward_a=01 when the add reaches EX.
- add rd=5 then sub rs=5, rt=5 -> forward_a=10 and forward_b=10; insert 1 independent instruction between them instead -> both 01.
- Two writers to r6 back-to-back, then reader of r6 -> forward selects 10 (EX/MEM priority); with writer rd=0 -> forward 00, no stall.
- id_flush=1 with a beq bundle (id_mem=3'b100, id_ex=4'b0010) -> mem_branch stays 0 for 2 cycles; reset asserted mid-stream -> wb_reg_write=0 on the next cycle.
